// File: rtl/mips_microsystem.sv
// mips_microsystem
// FPGA demo-board system: a 32-bit ALU driven by DIP switches (operands) and
// user keys (operation select), with the result shown on 32 LEDs, on two
// 4-digit 7-segment tube groups, and sent as 4 bytes over a UART transmitter.
// Bytes received on the UART are shown on tube group 2 alongside the last op.
//
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   RxD / TxD                    UART 8N1, idle high
//   dip_switch0..7 [7:0]         A = {sw3,sw2,sw1,sw0}, B = {sw7,sw6,sw5,sw4}
//   user_key [7:0]               active-high keys, key i selects operation i
//   lights [31:0]                current result
//   digital_tube0/1/2 [7:0]      active-low segments {dp,g,f,e,d,c,b,a}
//   digital_Sel0/1/2 [3:0]       active-low one-hot digit select
//
// Parameters:
//   CLKS_PER_BIT   UART bit period in clocks (must be >= 2)
//   SCAN_DIV       clocks each tube digit is displayed
module mips_microsystem #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SCAN_DIV     = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RxD,
    input  logic [7:0]  dip_switch0,
    input  logic [7:0]  dip_switch1,
    input  logic [7:0]  dip_switch2,
    input  logic [7:0]  dip_switch3,
    input  logic [7:0]  dip_switch4,
    input  logic [7:0]  dip_switch5,
    input  logic [7:0]  dip_switch6,
    input  logic [7:0]  dip_switch7,
    input  logic [7:0]  user_key,
    output logic        TxD,
    output logic [31:0] lights,
    output logic [7:0]  digital_tube0,
    output logic [7:0]  digital_tube1,
    output logic [7:0]  digital_tube2,
    output logic [3:0]  digital_Sel0,
    output logic [3:0]  digital_Sel1,
    output logic [3:0]  digital_Sel2
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [31:0] op_a, op_b;
    assign op_a = {dip_switch3, dip_switch2, dip_switch1, dip_switch0};
    assign op_b = {dip_switch7, dip_switch6, dip_switch5, dip_switch4};

    function automatic logic [31:0] alu(input logic [2:0] sel,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (sel)
            3'd0:    alu = a + b;
            3'd1:    alu = a - b;
            3'd2:    alu = a & b;
            3'd3:    alu = a | b;
            3'd4:    alu = a ^ b;
            3'd5:    alu = {31'd0, $signed(a) < $signed(b)};
            3'd6:    alu = a << b[4:0];
            default: alu = a >> b[4:0];
        endcase
    endfunction

    function automatic logic [7:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: hex_font = 8'hC0;  4'h1: hex_font = 8'hF9;
            4'h2: hex_font = 8'hA4;  4'h3: hex_font = 8'hB0;
            4'h4: hex_font = 8'h99;  4'h5: hex_font = 8'h92;
            4'h6: hex_font = 8'h82;  4'h7: hex_font = 8'hF8;
            4'h8: hex_font = 8'h80;  4'h9: hex_font = 8'h90;
            4'hA: hex_font = 8'h88;  4'hB: hex_font = 8'h83;
            4'hC: hex_font = 8'hC6;  4'hD: hex_font = 8'hA1;
            4'hE: hex_font = 8'h86;  default: hex_font = 8'h8E;
        endcase
    endfunction

    // Bit 0 is transmitted first: per byte a start 0, 8 data bits LSB first,
    // then a stop 1, bytes ordered LSB byte first.
    function automatic logic [39:0] build_frame(input logic [31:0] word);
        build_frame = '0;
        for (int j = 0; j < 4; j++) begin
            build_frame[10*j]        = 1'b0;
            build_frame[10*j+1 +: 8] = word[8*j +: 8];
            build_frame[10*j+9]      = 1'b1;
        end
    endfunction

    // ---------------- key press detection and ALU ----------------
    logic [7:0]  key_q, key_rise;
    logic        press;
    logic [2:0]  press_idx;
    logic [31:0] alu_out;
    logic [31:0] result, result_next;
    logic [2:0]  op, op_next;

    // Descending scan so the lowest rising key index is the one kept.
    always_comb begin
        key_rise  = user_key & ~key_q;
        press     = |key_rise;
        press_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (key_rise[i]) press_idx = 3'(i);
        end
        alu_out     = alu(press_idx, op_a, op_b);
        result_next = press ? alu_out : result;
        op_next     = press ? press_idx : op;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q  <= '0;
            result <= '0;
            op     <= '0;
        end else begin
            key_q  <= user_key;
            result <= result_next;
            op     <= op_next;
        end
    end

    assign lights = result;

    // ---------------- UART transmitter ----------------
    tx_state_t        tx_state, tx_state_next;
    logic [39:0]      tx_frame;
    logic [CW-1:0]    tx_cnt;
    logic [5:0]       tx_bit;
    logic             tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_next;
    end

    // TX_LOAD is a one-cycle gap so the start bit begins the cycle after the
    // press that snapshotted the result.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE: if (press) tx_state_next = TX_LOAD;
            TX_LOAD: tx_state_next = TX_SEND;
            TX_SEND: if (tx_tick && tx_bit == 6'd39) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            TxD      <= 1'b1;
            tx_frame <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    TxD <= 1'b1;
                    if (press) tx_frame <= build_frame(alu_out);
                end
                TX_LOAD: begin
                    TxD      <= tx_frame[0];
                    tx_frame <= tx_frame >> 1;
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                end
                TX_SEND: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit == 6'd39) begin
                            TxD <= 1'b1;
                        end else begin
                            TxD      <= tx_frame[0];
                            tx_frame <= tx_frame >> 1;
                            tx_bit   <= tx_bit + 6'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: TxD <= 1'b1;
            endcase
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t     rx_state, rx_state_next;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte, rx_byte_next;
    logic          rx_tick;

    assign rx_tick = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_next;
    end

    // A start needs a genuine high-to-low edge, so a line that is low from
    // reset or stays low after a frame never starts another one.
    always_comb begin
        rx_state_next = rx_state;
        rx_byte_next  = rx_byte;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_state_next = RX_START;
            RX_START: if (rx_cnt == BIT_HALF)
                          rx_state_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_next = RX_IDLE;
                    if (rx_s2) rx_byte_next = rx_shift;
                end
            end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    // Synchronizers reset low so a line already high at reset release does
    // not look like an edge, and a low line cannot either.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b0;
            rx_s2    <= 1'b0;
            rx_prev  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
        end else begin
            rx_s1   <= RxD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_byte <= rx_byte_next;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                RX_START: rx_cnt <= (rx_cnt == BIT_HALF) ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
                default: rx_cnt <= '0;
            endcase
        end
    end

    // ---------------- display scan ----------------
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit, digit_next;
    logic          scan_wrap;
    logic [15:0]   tube2_content;

    assign scan_wrap     = (scan_cnt == SCAN_LAST);
    assign digit_next    = scan_wrap ? digit + 2'd1 : digit;
    assign tube2_content = {rx_byte_next, 5'b0, op_next};

    // Outputs are computed from next-state values so the registered display
    // tracks digit advances and content updates on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt      <= '0;
            digit         <= '0;
            digital_Sel0  <= 4'b1110;
            digital_Sel1  <= 4'b1110;
            digital_Sel2  <= 4'b1110;
            digital_tube0 <= 8'hC0;
            digital_tube1 <= 8'hC0;
            digital_tube2 <= 8'hC0;
        end else begin
            scan_cnt      <= scan_wrap ? '0 : scan_cnt + 1'b1;
            digit         <= digit_next;
            digital_Sel0  <= ~(4'b0001 << digit_next);
            digital_Sel1  <= ~(4'b0001 << digit_next);
            digital_Sel2  <= ~(4'b0001 << digit_next);
            digital_tube0 <= hex_font(result_next[{digit_next, 2'b00} +: 4]);
            digital_tube1 <= hex_font(result_next[{1'b1, digit_next, 2'b00} +: 4]);
            digital_tube2 <= hex_font(tube2_content[{digit_next, 2'b00} +: 4]);
        end
    end

endmodule

// File: tb/tb_mips_microsystem.sv
// Self-checking bench for mips_microsystem with short UART bit period and
// fast display scan so every feature is reachable in a few thousand clocks.
module tb_mips_microsystem;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        RxD;
    logic [7:0]  sw [8];
    logic [7:0]  user_key;
    logic        TxD;
    logic [31:0] lights;
    logic [7:0]  tube0, tube1, tube2;
    logic [3:0]  sel0, sel1, sel2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_microsystem #(.CLKS_PER_BIT(CPB), .SCAN_DIV(2)) dut (
        .clk(clk), .reset(reset), .RxD(RxD),
        .dip_switch0(sw[0]), .dip_switch1(sw[1]), .dip_switch2(sw[2]),
        .dip_switch3(sw[3]), .dip_switch4(sw[4]), .dip_switch5(sw[5]),
        .dip_switch6(sw[6]), .dip_switch7(sw[7]),
        .user_key(user_key), .TxD(TxD), .lights(lights),
        .digital_tube0(tube0), .digital_tube1(tube1), .digital_tube2(tube2),
        .digital_Sel0(sel0), .digital_Sel1(sel1), .digital_Sel2(sel2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic setOperands(input logic [31:0] a, input logic [31:0] b);
        {sw[3], sw[2], sw[1], sw[0]} = a;
        {sw[7], sw[6], sw[5], sw[4]} = b;
    endtask

    // Raises the keys for one clock; returns at the negedge after the edge
    // that sampled the press, with the keys released.
    task automatic applyStimulus(input logic [7:0] keys);
        @(negedge clk);
        user_key = keys;
        @(negedge clk);
        user_key = 8'h00;
    endtask

    task automatic pressAndCheck(input string tag, input logic [7:0] keys,
                                 input logic [31:0] expected);
        applyStimulus(keys);
        checkOutput(tag, lights, expected);
        repeat (170) @(negedge clk);
    endtask

    task automatic checkTxQuiet(input string tag, input int cycles);
        logic low_seen;
        low_seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) low_seen = 1'b1;
        end
        checkOutput(tag, {31'd0, low_seen}, 32'd0);
    endtask

    // Waits (bounded) for the requested digit on a tube group and checks it.
    task automatic checkDigit(input string tag, input int grp, input int d,
                              input logic [7:0] expected);
        logic [3:0] want, cur_sel;
        logic [7:0] cur_tube;
        int n;
        want = ~(4'b0001 << d);
        n = 0;
        cur_sel = 4'hx;
        cur_tube = 8'hx;
        while (n < 20) begin
            @(negedge clk);
            cur_sel  = (grp == 0) ? sel0 : (grp == 1) ? sel1 : sel2;
            cur_tube = (grp == 0) ? tube0 : (grp == 1) ? tube1 : tube2;
            if (cur_sel == want) break;
            n++;
        end
        checkOutput({tag, "_sel"}, {28'd0, cur_sel}, {28'd0, want});
        checkOutput(tag, {24'd0, cur_tube}, {24'd0, expected});
    endtask

    task automatic sendRx(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RxD = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        RxD = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    logic [3:0]  exp_sel [4];
    logic [7:0]  exp_beef [4];
    logic [31:0] tx_word;
    logic [7:0]  got_byte;
    int          n;

    initial begin
        exp_sel  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_beef = '{8'h8E, 8'h86, 8'h86, 8'h83};
        reset = 1'b1;
        RxD = 1'b0;
        user_key = 8'h00;
        setOperands(32'd0, 32'd0);

        // Reset state, with RxD held low from reset onwards.
        repeat (10) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_lights", lights, 32'd0);
        checkOutput("reset_txd", {31'd0, TxD}, 32'd1);
        checkOutput("reset_sel0", {28'd0, sel0}, 32'h0000000E);
        checkOutput("reset_tube0", {24'd0, tube0}, 32'h000000C0);
        repeat (1000) @(negedge clk);
        checkOutput("idle_lights", lights, 32'd0);
        checkOutput("idle_txd", {31'd0, TxD}, 32'd1);
        for (int d = 0; d < 4; d++) checkDigit("idle_tube0", 0, d, 8'hC0);
        checkDigit("idle_rx_hi", 2, 3, 8'hC0);
        checkDigit("idle_rx_lo", 2, 2, 8'hC0);
        RxD = 1'b1;
        repeat (10) @(negedge clk);
        checkDigit("idle_rx_after_rise", 2, 3, 8'hC0);

        // Arithmetic.
        setOperands(32'd5, 32'd3);
        pressAndCheck("add_5_3", 8'h01, 32'd8);
        pressAndCheck("sub_5_3", 8'h02, 32'd2);
        pressAndCheck("slt_5_3", 8'h20, 32'd0);
        pressAndCheck("sll_5_3", 8'h40, 32'h28);
        setOperands(32'hFFFF_FFFF, 32'd1);
        pressAndCheck("slt_m1_1", 8'h20, 32'd1);
        pressAndCheck("add_wrap", 8'h01, 32'd0);
        pressAndCheck("srl_m1_1", 8'h80, 32'h7FFF_FFFF);

        // Key held: only the rising edge counts.
        setOperands(32'hF0, 32'hFF);
        @(negedge clk);
        user_key = 8'h04;
        @(negedge clk);
        checkOutput("hold_first", lights, 32'hF0);
        setOperands(32'h0F, 32'hFF);
        repeat (20) @(negedge clk);
        checkOutput("hold_single", lights, 32'hF0);
        user_key = 8'h00;
        repeat (170) @(negedge clk);

        // Simultaneous rise of key0 and key2: add wins.
        setOperands(32'd5, 32'd3);
        pressAndCheck("prio_add", 8'h05, 32'd8);

        // UART TX frame content and timing.
        setOperands(32'h1234_0000, 32'h5678);
        @(negedge clk);
        user_key = 8'h01;
        @(negedge clk);
        user_key = 8'h00;
        checkOutput("tx_lights", lights, 32'h1234_5678);
        checkOutput("tx_not_yet", {31'd0, TxD}, 32'd1);
        @(negedge clk);
        checkOutput("tx_start_edge", {31'd0, TxD}, 32'd0);
        @(negedge clk);
        tx_word = 32'h1234_5678;
        for (int j = 0; j < 4; j++) begin
            got_byte = 8'h00;
            for (int b = 0; b < 10; b++) begin
                if (b == 0) checkOutput("tx_start_bit", {31'd0, TxD}, 32'd0);
                else if (b == 9) checkOutput("tx_stop_bit", {31'd0, TxD}, 32'd1);
                else got_byte[b-1] = TxD;
                repeat (CPB) @(negedge clk);
            end
            checkOutput("tx_byte", {24'd0, got_byte}, {24'd0, tx_word[8*j +: 8]});
        end
        checkTxQuiet("tx_idle_after", 100);

        // A press during a frame updates lights but sends nothing extra.
        setOperands(32'd5, 32'd3);
        applyStimulus(8'h01);
        checkOutput("busy_first", lights, 32'd8);
        repeat (20) @(negedge clk);
        applyStimulus(8'h02);
        checkOutput("busy_second", lights, 32'd2);
        repeat (150) @(negedge clk);
        checkTxQuiet("busy_no_second_frame", 200);

        // Reset in the middle of a frame (byte 0 = 0x08, data bit low here).
        applyStimulus(8'h01);
        repeat (30) @(negedge clk);
        checkOutput("midframe_low", {31'd0, TxD}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_txd", {31'd0, TxD}, 32'd1);
        checkOutput("midreset_lights", lights, 32'd0);
        reset = 1'b0;
        checkTxQuiet("midreset_quiet", 50);

        // UART RX: valid frame shown, bad stop bit discarded.
        sendRx(8'hA5, 1'b1);
        checkDigit("rx_a5_hi", 2, 3, 8'h88);
        checkDigit("rx_a5_lo", 2, 2, 8'h92);
        sendRx(8'h3C, 1'b0);
        checkDigit("rx_badstop_hi", 2, 3, 8'h88);
        checkDigit("rx_badstop_lo", 2, 2, 8'h92);

        // Scan order and rate with result 0x0000BEEF.
        setOperands(32'h0000_BEEF, 32'd0);
        applyStimulus(8'h10);
        checkOutput("xor_beef", lights, 32'h0000_BEEF);
        n = 0;
        while (sel0 == 4'b1110 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (sel0 != 4'b1110 && n < 20) begin @(negedge clk); n++; end
        checkOutput("scan_sync", {31'd0, n < 20}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("scan_sel0", {28'd0, sel0}, {28'd0, exp_sel[k]});
            checkOutput("scan_sel1", {28'd0, sel1}, {28'd0, exp_sel[k]});
            checkOutput("scan_tube0", {24'd0, tube0}, {24'd0, exp_beef[k]});
            checkOutput("scan_tube1", {24'd0, tube1}, 32'h000000C0);
            repeat (2) @(negedge clk);
        end
        checkOutput("scan_wrap", {28'd0, sel0}, 32'h0000000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
